// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: collects request events into a pending register and
// offers the highest-priority enabled channel over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      async active-high reset
//   req[7:0]   request events, set pending bits
//   mask[7:0]  per-channel service enable
//   out_ready  consumer accepts the offered index
//   lost_clr   synchronous clear of lost_cnt
//   out_valid  index offer valid
//   out_id     offered channel index (0 = highest priority)
//   pending    registered pending vector, unmasked
//   lost_cnt   saturating count of cycles that lost an event

module priority_encoder (
    input  logic [7:0] in,
    output logic [2:0] out
);

    // Lowest set index wins; result is don't-care when in == 0.
    always_comb begin
        out = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (in[i]) out = 3'(i);
        end
    end

endmodule

module irq_pending_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       out_ready,
    input  logic       lost_clr,
    output logic       out_valid,
    output logic [2:0] out_id,
    output logic [7:0] pending,
    output logic [7:0] lost_cnt
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [7:0] cand;
    logic [7:0] clr;
    logic [7:0] pend_d;
    logic [7:0] lost_vec;
    logic [2:0] enc;
    logic [2:0] id_d;
    logic       any;
    logic       lost;

    assign cand = pending & mask;
    assign any  = |cand;

    priority_encoder u_enc (
        .in  (cand),
        .out (enc)
    );

    // Priority is only sampled in IDLE; the offer is frozen until accepted.
    always_comb begin
        state_d   = state;
        id_d      = out_id;
        out_valid = 1'b0;
        clr       = 8'h00;
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_d = OFFER;
                    id_d    = enc;
                end
            end
            OFFER: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d     = IDLE;
                    clr[out_id] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new event on the clearing edge survives and is not a loss.
    assign pend_d   = req | (pending & ~clr);
    assign lost_vec = req & pending & ~clr;
    assign lost     = |lost_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            out_id   <= 3'd0;
            pending  <= 8'h00;
            lost_cnt <= 8'h00;
        end else begin
            state   <= state_d;
            out_id  <= id_d;
            pending <= pend_d;
            if (lost_clr) begin
                lost_cnt <= 8'h00;
            end else if (lost && (lost_cnt != 8'hFF)) begin
                lost_cnt <= lost_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Upstream request-collection stage for the 8-to-3 `priority_encoder`. Captures single-cycle request events on eight channels into a pending register, applies an enable mask, and feeds the masked pending vector to an internal `priority_encoder` instance. The resulting channel index is offered to a consumer over a valid/ready handshake, and the serviced pending bit is cleared on acceptance. Channel 0 has the highest priority; channel 7 has the lowest.

## Interface
- No parameters. Channel count is fixed at 8 to match `priority_encoder`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  8  request events; `req[i]=1` in a cycle sets `pending[i]` at that edge.
- `mask`  in  8  `1` enables channel i for service. Masked channels still latch into pending.
- `out_ready`  in  1  consumer accepts the offered index.
- `lost_clr`  in  1  synchronous clear of `lost_cnt`.
- `out_valid`  out  1  index offer valid.
- `out_id`  out  3  offered channel index.
- `pending`  out  8  registered pending vector (unmasked).
- `lost_cnt`  out  8  saturating count of cycles in which at least one request event was lost.

## Operation
- **Combinational path:** `cand = pending & mask`; `any = |cand`.
  - `enc` = `priority_encoder(cand)` gives the lowest set index of `cand`.
  - `enc` is meaningless when `any=0`; never use it without `any`.
- **FSM, two states:**
  - **IDLE:** `out_valid=0`. If `any`, latch `out_id<=enc` and go to OFFER.
  - **OFFER:** `out_valid=1`.
    - `out_id` is held stable until acceptance.
    - Changes to `mask` or `pending` during OFFER do not alter or withdraw the offer.
    - On `out_valid & out_ready`: clear `pending[out_id]`, return to IDLE.
- **Pending update per bit, per edge:** `pending[i] <= req[i] | (pending[i] & ~clr[i])`.
  - `clr[i] = (state==OFFER) & out_ready & (out_id==i)`.
  - A set on the same edge as a clear wins: a new event is kept, not counted lost.
- **Lost event:** `req[i]=1` while `pending[i]=1` and `clr[i]=0`.
  - `lost_cnt` increments by exactly 1 per cycle in which any channel loses, regardless of how many channels lose.
  - Saturates at 255.
  - `lost_clr` wins over a simultaneous increment: result is 0.
- A masked channel stays pending indefinitely. It becomes eligible when its mask bit is set, subject to priority.

## Timing
- **Reset values:**
  - `out_valid=0`, `out_id=3'd0`, `pending=8'h00`, `lost_cnt=8'h00`, state IDLE.
  - Asserting `reset` mid-offer drops the offer asynchronously, with no clear handshake.
- **Latency:** `req[i]` high in cycle 0 gives `pending[i]=1` in cycle 1, and `out_valid=1` with `out_id=i` in cycle 2 (enabled, highest-priority case).
- **Handshake:** accepted in cycle t means:
  - `out_valid=0` and the pending bit is cleared in cycle t+1.
  - The next offer comes no earlier than cycle t+2.
  - Maximum throughput is one index per 2 cycles.
- `out_ready` may be held high continuously. `out_ready` during IDLE has no effect.
- Priority is resampled only in IDLE. A higher-priority request arriving during OFFER is served next, not preemptively.

## Test plan
- **Reset then single request:** reset, then `req=8'h20` for one cycle, `mask=8'hFF`, `out_ready=1`.
  - Expect `out_valid` and `out_id=5` two cycles after the request.
  - Expect `pending=8'h00` the cycle after acceptance.
- **Priority order:** `req=8'hA6` in one cycle, `out_ready=1`.
  - Expect offers in order 1, 2, 5, 7, each 2 cycles apart.
  - Expect `pending=8'h00` after the fourth acceptance.
- **Masking and hold:** `req=8'h03`, `mask=8'hFE`, `out_ready=0` for 5 cycles.
  - Expect `out_id=1` held with `out_valid=1` throughout.
  - Then set `mask=8'hFF` and `out_ready=1`: expect acceptance of 1, then an offer of 0.
- **Set/clear collision and loss counting:**
  - While offering ch 3 with `out_ready=1`, pulse `req[3]`: expect `pending[3]` to remain 1, `lost_cnt` unchanged, and a re-offer of 3.
  - Pulse `req[3]` again while ch 3 is pending and not accepted: expect `lost_cnt=1`.
- **Saturation and clear:**
  - Hold `req=8'h01` with `out_ready=0` for 300 cycles: expect `lost_cnt=255`, no wrap.
  - Assert `lost_clr` in a cycle that also loses an event: expect `lost_cnt=0` the next cycle.
- **Async reset mid-offer:** assert `reset` between clock edges while `out_valid=1` with `pending=8'h81`.
  - Expect `out_valid=0` and `pending=0` immediately, with no edge required.
